amp_i2c_target: RTL and testbench

AMP_I2C_TARGET -- requirements
Module: amp_i2c_target

---
 rtl/amp_i2c_target.sv | 258 +++++++++++++++++++++++++
 tb/tb_amp_i2c_target.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/amp_i2c_target.sv
// amp_i2c_target: I2C target that exposes an 8-bit register pointer and write strobe.
// Define AMP_I2C_TARGET_READ_EN to add master-read transfers; otherwise reads are NACKed.
module amp_i2c_target #(
    parameter logic [6:0] I2C_ADDR = 7'h20
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       scl,
    input  logic       sdai,
    output logic       sdao,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t     r_state;
    logic       r_scl_s1;
    logic       r_scl_s2;
    logic       r_scl_d;
    logic       r_sda_s1;
    logic       r_sda_s2;
    logic       r_sda_d;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_ack_drv;
    logic       r_sdao;
    logic [7:0] r_ptr;
    logic [7:0] r_wdata;
    logic       r_we;
`ifdef AMP_I2C_TARGET_READ_EN
    logic       r_rw;
`else
    logic       w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
`endif

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_last;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_last     = (r_bitcnt == 3'd7);
    assign w_byte     = {r_shift, r_sda_s2};

    assign sdao      = r_sdao;
    assign reg_addr  = r_ptr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sdai;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // ACK states use r_ack_drv to tell the ACK-starting SCL fall from the ACK-ending one.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_ack_drv <= 1'b0;
            r_sdao    <= 1'b1;
            r_ptr     <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
`ifdef AMP_I2C_TARGET_READ_EN
            r_rw      <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_ptr <= r_ptr + 8'd1;
            end

            if (w_stop) begin
                r_state   <= IDLE;
                r_sdao    <= 1'b1;
                r_ack_drv <= 1'b0;
                r_bitcnt  <= '0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_sdao    <= 1'b1;
                r_ack_drv <= 1'b0;
                r_bitcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE, IGNORE: begin
                        r_sdao <= 1'b1;
                    end

                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) begin
                                if (w_byte[7:1] != I2C_ADDR) begin
                                    r_state <= IGNORE;
                                end else if (!w_byte[0]) begin
                                    r_state <= ADDR_ACK;
`ifdef AMP_I2C_TARGET_READ_EN
                                    r_rw    <= 1'b0;
`endif
                                end else begin
`ifdef AMP_I2C_TARGET_READ_EN
                                    r_state <= ADDR_ACK;
                                    r_rw    <= 1'b1;
`else
                                    r_state <= IGNORE;
`endif
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sdao    <= 1'b0;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= '0;
`ifdef AMP_I2C_TARGET_READ_EN
                                if (r_rw) begin
                                    r_state <= RDATA;
                                    r_sdao  <= reg_rdata[7];
                                    r_shift <= reg_rdata[6:0];
                                end else begin
                                    r_state <= REG;
                                    r_sdao  <= 1'b1;
                                end
`else
                                r_state <= REG;
                                r_sdao  <= 1'b1;
`endif
                            end
                        end
                    end

                    REG: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) begin
                                r_ptr   <= w_byte;
                                r_state <= REG_ACK;
                            end
                        end
                    end

                    REG_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sdao    <= 1'b0;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_sdao    <= 1'b1;
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= '0;
                                r_state   <= WDATA;
                            end
                        end
                    end

                    WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) begin
                                r_wdata <= w_byte;
                                r_we    <= 1'b1;
                                r_state <= WDATA_ACK;
                            end
                        end
                    end

`ifdef AMP_I2C_TARGET_READ_EN
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) begin
                                r_state <= RDATA_ACK;
                            end
                        end else if (w_scl_fall) begin
                            r_sdao  <= r_shift[6];
                            r_shift <= {r_shift[5:0], 1'b1};
                        end
                    end

                    // r_ack_drv here records that the master ACKed on the 9th rise.
                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (!r_sda_s2) begin
                                r_ptr     <= r_ptr + 8'd1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_state <= IGNORE;
                                r_sdao  <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_ack_drv) begin
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= '0;
                                r_state   <= RDATA;
                                r_sdao    <= reg_rdata[7];
                                r_shift   <= reg_rdata[6:0];
                            end else begin
                                r_sdao <= 1'b1;
                            end
                        end
                    end
`endif

                    default: begin
                        r_state <= IDLE;
                        r_sdao  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed bench for amp_i2c_target: bit-banged I2C master, register-write scoreboard.
module tb_amp_i2c_target;

    localparam int Q = 200;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sdai;
    logic       sdao;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int          obs_rd = 0;
    int          checks = 0;
    int          failures = 0;

    assign sdai      = m_sda & sdao;
    assign reg_rdata = mem[reg_addr];

    always #5 clk_in = ~clk_in;

    amp_i2c_target #(.I2C_ADDR(7'h20)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .scl      (scl),
        .sdai     (sdai),
        .sdao     (sdao),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    always @(negedge clk_in) begin
        if (reg_we === 1'b1) obs_q.push_back({reg_addr, reg_wdata});
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        m_sda = b;  #Q;
        scl = 1'b1; #Q;
        seen = sdao;
        #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], dummy);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d, output logic rel9);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(!master_ack, rel9);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, " we_count"}, 16'(obs_q.size() - obs_rd), 16'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            check({tag, " we_addr_data"}, obs_q[obs_rd], exp_q.pop_front());
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic run_basic_write(input string tag);
        logic ack;
        bus_start();
        send_byte(8'h40, ack);
        check({tag, " addr_ack"}, 16'(ack), 16'h0);
        send_byte(8'h40, ack);
        check({tag, " ptr_ack"}, 16'(ack), 16'h0);
        check({tag, " busy_mid"}, 16'(busy), 16'h1);
        exp_q.push_back({8'h40, 8'h18});
        send_byte(8'h18, ack);
        check({tag, " data_ack"}, 16'(ack), 16'h0);
        bus_stop();
        #Q;
        check({tag, " busy_after_stop"}, 16'(busy), 16'h0);
        check({tag, " sdao_idle"}, 16'(sdao), 16'h1);
        compare_writes(tag);
        check({tag, " ptr_after"}, 16'(reg_addr), 16'h41);
    endtask

    initial begin
        logic       ack;
        logic       seen;
        logic [7:0] rd;
        logic       rel;

        reset = 1'b1;
        scl   = 1'b1;
        m_sda = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h35] = 8'h08;
        #20;
        check("rst sdao", 16'(sdao), 16'h1);
        check("rst reg_we", 16'(reg_we), 16'h0);
        check("rst reg_addr", 16'(reg_addr), 16'h0);
        check("rst reg_wdata", 16'(reg_wdata), 16'h0);
        check("rst busy", 16'(busy), 16'h0);
        reset = 1'b0;
        #Q;

        run_basic_write("wr1");

        // Address mismatch: no ACKs anywhere, target parked until STOP.
        bus_start();
        send_byte(8'h42, ack);
        check("mis addr_ack", 16'(ack), 16'h1);
        send_byte(8'h35, ack);
        check("mis b1_ack", 16'(ack), 16'h1);
        send_byte(8'h08, ack);
        check("mis b2_ack", 16'(ack), 16'h1);
        check("mis busy_ignore", 16'(busy), 16'h1);
        bus_stop();
        #Q;
        check("mis busy_after_stop", 16'(busy), 16'h0);
        compare_writes("mis");

        // Burst across the pointer wrap.
        bus_start();
        send_byte(8'h40, ack);
        check("burst addr_ack", 16'(ack), 16'h0);
        send_byte(8'hFE, ack);
        check("burst ptr_ack", 16'(ack), 16'h0);
        exp_q.push_back({8'hFE, 8'h11});
        send_byte(8'h11, ack);
        check("burst d0_ack", 16'(ack), 16'h0);
        exp_q.push_back({8'hFF, 8'h22});
        send_byte(8'h22, ack);
        check("burst d1_ack", 16'(ack), 16'h0);
        exp_q.push_back({8'h00, 8'h33});
        send_byte(8'h33, ack);
        check("burst d2_ack", 16'(ack), 16'h0);
        bus_stop();
        #Q;
        compare_writes("burst");
        check("burst ptr_final", 16'(reg_addr), 16'h01);

`ifdef AMP_I2C_TARGET_READ_EN
        bus_start();
        send_byte(8'h40, ack);
        check("rd addr_w_ack", 16'(ack), 16'h0);
        send_byte(8'h35, ack);
        check("rd ptr_ack", 16'(ack), 16'h0);
        bus_start();
        send_byte(8'h41, ack);
        check("rd addr_r_ack", 16'(ack), 16'h0);
        read_byte(1'b0, rd, rel);
        check("rd data_bits", 16'(rd), 16'h08);
        check("rd released_9th", 16'(rel), 16'h1);
        bus_stop();
        #Q;
        check("rd busy_after_stop", 16'(busy), 16'h0);
        check("rd ptr_kept", 16'(reg_addr), 16'h35);
        compare_writes("rd");
`else
        bus_start();
        send_byte(8'h41, ack);
        check("rdoff addr_ack", 16'(ack), 16'h1);
        bus_stop();
        #Q;
        check("rdoff busy_after_stop", 16'(busy), 16'h0);
        compare_writes("rdoff");
`endif

        // Reset during the 4th bit of a data byte (0x5A).
        bus_start();
        send_byte(8'h40, ack);
        check("rst_mid addr_ack", 16'(ack), 16'h0);
        send_byte(8'h50, ack);
        check("rst_mid ptr_ack", 16'(ack), 16'h0);
        bus_bit(1'b0, seen);
        bus_bit(1'b1, seen);
        bus_bit(1'b0, seen);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #100;
        reset = 1'b1;
        #1;
        check("rst_mid sdao", 16'(sdao), 16'h1);
        check("rst_mid reg_we", 16'(reg_we), 16'h0);
        check("rst_mid reg_addr", 16'(reg_addr), 16'h0);
        check("rst_mid reg_wdata", 16'(reg_wdata), 16'h0);
        check("rst_mid busy", 16'(busy), 16'h0);
        #99;
        m_sda = 1'b1;
        scl   = 1'b1;
        #Q;
        reset = 1'b0;
        #Q;
        compare_writes("rst_mid");

        run_basic_write("wr2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
